cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Condition/flag stage directly downstream of the ALU in the ARM-subset datapath.
- Captures the ALU's 4-bit NZCV flags into an architectural flag register under per-group write enables.
- Evaluates the instruction's 4-bit condition field against the registered flags.
- Gates the decoder's PC-source, register-write and memory-write requests so that only condition-passing instructions commit.

Parameters:
- CNT_W, 32, width of the optional performance counters; legal range 8..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- Valid  input  1  an instruction is present this cycle
- Stall  input  1  hold this stage; no commit, no flag update
- Flush  input  1  squash the current instruction; no commit, no flag update
- Cond  input  4  instruction condition field [31:28]
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  input  2  [1]=write N,Z; [0]=write C,V
- PCS  input  1  decoder requests PC write (branch or write to R15)
- RegW  input  1  decoder requests register write
- MemW  input  1  decoder requests memory write
- NoWrite  input  1  compare-class instruction (CMP/CMN/TST/TEQ); suppresses RegWrite
- Flags  output  4  registered architectural {N,Z,C,V}
- CondEx  output  1  condition passes against registered Flags
- PCSrc  output  1  gated PCS
- RegWrite  output  1  gated RegW
- MemWrite  output  1  gated MemW
- ExecCnt  output  CNT_W  committed-instruction count; present only with the optional feature
- SquashCnt  output  CNT_W  condition-failed count; present only with the optional feature

Behaviour:
- Reset: asynchronous on rst_n low. Flags=4'b0000; counters=0. Combinational outputs follow from reset Flags.
- CondEx: combinational, from registered Flags only; never from same-cycle ALUFlags.
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (treated as never)
- Commit qualifier: go = Valid & ~Stall & ~Flush & CondEx.
- Gated outputs (combinational, zero added latency):
  - PCSrc = go & PCS
  - RegWrite = go & RegW & ~NoWrite
  - MemWrite = go & MemW
- Flag update on posedge clk when go:
  - FlagW[1] set: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0] set: Flags[1:0] <= ALUFlags[1:0].
  - Otherwise that group holds.
- Flag latency: new flags are visible on Flags/CondEx one cycle after the setting instruction. A dependent conditional instruction in the next cycle sees the updated value; no bypass is needed.
- Condition-failed instruction: no flag change, all gated outputs 0, even when FlagW is nonzero.
- Stall and Flush asserted together: Flush dominates; outcome is identical (nothing commits, flags hold).
- Valid=0: identical to a squash. Counters unchanged.
- Inputs other than Valid/Stall/Flush are don't-care when Valid=0.
- Reset mid-operation: flags clear immediately, asynchronously. The first instruction after reset evaluates against 0000, so EQ fails and NE passes.

Optional Feature:
- Macro: COND_UNIT_PERF_CNT_EN.
- Defined:
  - ExecCnt increments on every cycle with go=1.
  - SquashCnt increments on every cycle with Valid & ~Stall & ~Flush & ~CondEx.
  - Both are CNT_W-bit, wrap modulo 2^CNT_W with no saturation, and reset to 0.
  - Stalled or flushed cycles count in neither.
- Undefined: ExecCnt and SquashCnt ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset: rst_n low mid-cycle with Flags=1111 -> Flags=0000 immediately. Cond=0000 gives CondEx=0; Cond=0001 gives CondEx=1.
- Flag groups: Valid=1, Cond=1110, FlagW=10, ALUFlags=1011, from Flags=0000 -> next cycle Flags=1000. Then FlagW=01, ALUFlags=0111 -> Flags=1011.
- Back-to-back dependency:
  - Cycle n: SUBS-style with ALUFlags=0100 (Z), FlagW=11.
  - Cycle n+1: Cond=0000, RegW=1 -> CondEx=1, RegWrite=1.
  - Same pair with Cond=0001 -> RegWrite=0 and flags unchanged at 0100.
- Signed conditions: Flags=1001 (N=1,V=1) -> GE=1, LT=0, GT=1, LE=0. Flags=1000 -> GE=0, LT=1, GT=0, LE=1.
- Squash paths: Cond=1110, PCS=RegW=MemW=1, FlagW=11.
  - Stall=1 -> all gated outputs 0, flags hold.
  - Flush=1 -> same.
  - NoWrite=1 -> RegWrite=0 while PCSrc=1 and MemWrite=1.
  - Cond=1111 -> all 0.
- Counters (macro defined, CNT_W=8): ExecCnt preloaded to 255 by 255 committing cycles, one more commit -> ExecCnt=0. 3 condition-failed cycles plus 2 stalled cycles -> SquashCnt=3.

Source files
------------

// File: rtl/cond_unit_if.sv
// cond_unit_if: condition-stage bus; ExecCnt/SquashCnt exist only with COND_UNIT_PERF_CNT_EN
interface cond_unit_if #(parameter int CNT_W = 32);
   logic       Valid, Stall, Flush;
   logic [3:0] Cond, ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic [3:0] Flags;
   logic       CondEx, PCSrc, RegWrite, MemWrite;
   if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
      $error("cond_unit_if: CNT_W must be 8..32");
   end
`ifdef COND_UNIT_PERF_CNT_EN
   logic [CNT_W-1:0] ExecCnt, SquashCnt;
   modport master (output Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
                   input Flags, CondEx, PCSrc, RegWrite, MemWrite, ExecCnt, SquashCnt);
   modport slave (input Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
                  output Flags, CondEx, PCSrc, RegWrite, MemWrite, ExecCnt, SquashCnt);
`else
   modport master (output Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
                   input Flags, CondEx, PCSrc, RegWrite, MemWrite);
   modport slave (input Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
                  output Flags, CondEx, PCSrc, RegWrite, MemWrite);
`endif
endinterface

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition evaluation and commit gating; COND_UNIT_PERF_CNT_EN adds counters
module cond_unit #(
   parameter int CNT_W = 32
) (
   input logic       clk,
   input logic       rst_n,
   cond_unit_if.slave bus
);
   logic [3:0] flags_q, flags_d;
   logic       n, z, c, v, cond_ex, go, live;
   assign {n, z, c, v} = flags_q;
   if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
      $error("cond_unit: CNT_W must be 8..32");
   end
   // Condition decode against the registered flags only, never same-cycle ALUFlags
   always_comb begin
      case (bus.Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = n ~^ v;
         4'b1011: cond_ex = n ^ v;
         4'b1100: cond_ex = ~z & (n ~^ v);
         4'b1101: cond_ex = z | (n ^ v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end
   // Commit qualifier and per-group next flags; a failed condition leaves both groups untouched
   always_comb begin
      live    = bus.Valid & ~bus.Stall & ~bus.Flush;
      go      = live & cond_ex;
      flags_d = {go & bus.FlagW[1] ? bus.ALUFlags[3:2] : flags_q[3:2],
                 go & bus.FlagW[0] ? bus.ALUFlags[1:0] : flags_q[1:0]};
   end
   assign bus.Flags    = flags_q;
   assign bus.CondEx   = cond_ex;
   assign bus.PCSrc    = go & bus.PCS;
   assign bus.RegWrite = go & bus.RegW & ~bus.NoWrite;
   assign bus.MemWrite = go & bus.MemW;
   // Architectural flag register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end
`ifdef COND_UNIT_PERF_CNT_EN
   logic [CNT_W-1:0] exec_q, exec_d, squash_q, squash_d;
   // Committed and condition-failed counts; stalled/flushed/idle cycles count in neither
   always_comb begin
      exec_d   = exec_q + CNT_W'(go);
      squash_d = squash_q + CNT_W'(live & ~cond_ex);
   end
   // Wrapping performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_q   <= '0;
         squash_q <= '0;
      end else begin
         exec_q   <= exec_d;
         squash_q <= squash_d;
      end
   end
   assign bus.ExecCnt   = exec_q;
   assign bus.SquashCnt = squash_q;
`endif
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed plus random checks of cond_unit against an ARM-condition reference model
module tb_cond_unit;
   localparam int CNT_W = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   cond_unit_if #(.CNT_W(CNT_W)) bus();
   cond_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int checks = 0;
   int failures = 0;
   logic [3:0] m_flags = 4'b0000;
   int m_exec = 0;
   int m_squash = 0;

   // ARM semantics: pairs of conditions share a predicate, odd code inverts it, 1111 never passes
   function automatic logic pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      if (cond == 4'b1111) return 1'b0;
      if (cond == 4'b1110) return 1'b1;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return base ^ cond[0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic va, st, fl, input logic [3:0] cond, alu, input logic [1:0] fw,
                        input logic pcs, rw, mw, nw);
      bus.Valid = va; bus.Stall = st; bus.Flush = fl; bus.Cond = cond; bus.ALUFlags = alu;
      bus.FlagW = fw; bus.PCS = pcs; bus.RegW = rw; bus.MemW = mw; bus.NoWrite = nw;
   endtask

   // Check combinational outputs for the driven inputs, clock once, advance the model, check Flags
   task automatic step(input string tag);
      logic live_e, go_e;
      #1;
      live_e = bus.Valid && !bus.Stall && !bus.Flush;
      go_e   = live_e && pass(bus.Cond, m_flags);
      chk({tag, ".condex"}, 32'(bus.CondEx), 32'(pass(bus.Cond, m_flags)));
      chk({tag, ".pcsrc"}, 32'(bus.PCSrc), 32'(go_e && bus.PCS));
      chk({tag, ".regwrite"}, 32'(bus.RegWrite), 32'(go_e && bus.RegW && !bus.NoWrite));
      chk({tag, ".memwrite"}, 32'(bus.MemWrite), 32'(go_e && bus.MemW));
`ifdef COND_UNIT_PERF_CNT_EN
      chk({tag, ".exec"}, 32'(bus.ExecCnt), 32'(m_exec));
      chk({tag, ".squash"}, 32'(bus.SquashCnt), 32'(m_squash));
`endif
      @(posedge clk);
      if (go_e) begin
         if (bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
         if (bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
         m_exec = (m_exec + 1) % (1 << CNT_W);
      end else if (live_e) begin
         m_squash = (m_squash + 1) % (1 << CNT_W);
      end
      #1;
      chk({tag, ".flags"}, 32'(bus.Flags), 32'(m_flags));
   endtask

   task automatic cond_at(input string tag, input logic [3:0] cond, input logic exp);
      bus.Valid = 1'b0;
      bus.Cond = cond;
      #1;
      chk(tag, 32'(bus.CondEx), 32'(exp));
   endtask

   task automatic rst_pulse();
      #2 rst_n = 1'b0;
      #1;
      m_flags = 4'b0000; m_exec = 0; m_squash = 0;
      chk("rst_pulse.flags", 32'(bus.Flags), 32'h0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
      #3;
      chk("reset.flags", 32'(bus.Flags), 32'h0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Async reset mid-cycle from Flags=1111
      drive(1, 0, 0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
      step("set1111");
      chk("set1111.const", 32'(bus.Flags), 32'hF);
      drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      m_flags = 4'b0000; m_exec = 0; m_squash = 0;
      chk("async_rst.flags", 32'(bus.Flags), 32'h0);
      cond_at("async_rst.eq", 4'b0000, 1'b0);
      cond_at("async_rst.ne", 4'b0001, 1'b1);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Flag groups written independently
      drive(1, 0, 0, 4'hE, 4'b1011, 2'b10, 0, 0, 0, 0);
      step("grp_nz");
      chk("grp_nz.const", 32'(bus.Flags), 32'b1000);
      drive(1, 0, 0, 4'hE, 4'b0111, 2'b01, 0, 0, 0, 0);
      step("grp_cv");
      chk("grp_cv.const", 32'(bus.Flags), 32'b1011);
      // Back-to-back dependency, EQ then NE
      drive(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
      step("subs1");
      drive(1, 0, 0, 4'b0000, 4'b1111, 2'b11, 0, 1, 0, 0);
      #1;
      chk("dep_eq.condex", 32'(bus.CondEx), 32'h1);
      chk("dep_eq.regwrite", 32'(bus.RegWrite), 32'h1);
      step("dep_eq");
      drive(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
      step("subs2");
      drive(1, 0, 0, 4'b0001, 4'b1111, 2'b11, 0, 1, 0, 0);
      #1;
      chk("dep_ne.regwrite", 32'(bus.RegWrite), 32'h0);
      step("dep_ne");
      chk("dep_ne.hold", 32'(bus.Flags), 32'b0100);
      // Signed conditions
      drive(1, 0, 0, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
      step("set1001");
      cond_at("f1001.ge", 4'b1010, 1'b1);
      cond_at("f1001.lt", 4'b1011, 1'b0);
      cond_at("f1001.gt", 4'b1100, 1'b1);
      cond_at("f1001.le", 4'b1101, 1'b0);
      drive(1, 0, 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
      step("set1000");
      cond_at("f1000.ge", 4'b1010, 1'b0);
      cond_at("f1000.lt", 4'b1011, 1'b1);
      cond_at("f1000.gt", 4'b1100, 1'b0);
      cond_at("f1000.le", 4'b1101, 1'b1);
      // Squash paths
      drive(1, 1, 0, 4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
      #1;
      chk("stall.any", 32'({bus.PCSrc, bus.RegWrite, bus.MemWrite}), 32'h0);
      step("stall");
      chk("stall.hold", 32'(bus.Flags), 32'b1000);
      drive(1, 0, 1, 4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
      step("flush");
      drive(1, 1, 1, 4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
      step("stall_flush");
      drive(0, 0, 0, 4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
      step("invalid");
      chk("squash.hold", 32'(bus.Flags), 32'b1000);
      drive(1, 0, 0, 4'hE, 4'b0110, 2'b00, 1, 1, 1, 1);
      #1;
      chk("nowrite.const", 32'({bus.PCSrc, bus.RegWrite, bus.MemWrite}), 32'b101);
      step("nowrite");
      drive(1, 0, 0, 4'hF, 4'b0110, 2'b11, 1, 1, 1, 0);
      #1;
      chk("never.const", 32'({bus.PCSrc, bus.RegWrite, bus.MemWrite}), 32'h0);
      step("never");
      chk("never.hold", 32'(bus.Flags), 32'b1000);
      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
               4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 3) == 0));
         step("rand");
      end
`ifdef COND_UNIT_PERF_CNT_EN
      // Counter wrap and squash counting
      rst_pulse();
      drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < 255; i++) step("preload");
      chk("exec.255", 32'(bus.ExecCnt), 32'd255);
      step("wrap");
      chk("exec.wrap", 32'(bus.ExecCnt), 32'd0);
      drive(1, 0, 0, 4'hF, 4'h0, 2'b11, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) step("cfail");
      drive(1, 1, 0, 4'hF, 4'h0, 2'b11, 1, 1, 1, 0);
      for (int i = 0; i < 2; i++) step("stalled");
      chk("squash.3", 32'(bus.SquashCnt), 32'd3);
      chk("exec.after", 32'(bus.ExecCnt), 32'd0);
`else
      rst_pulse();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
